ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It sits between ID and MEM and registers the ID->EX bus under stall control. It computes the ALU result, drives the data SRAM request for loads and stores, and forwards its write-back target to ID. It also owns the HI/LO registers: MULT/MULTU complete in one cycle, and DIV/DIVU use a 32-iteration restoring divider that stalls the pipeline through stallreq_for_ex.

Parameters:
ID_TO_EX_WD, 145, ID->EX bus width
EX_TO_MEM_WD, 76, EX->MEM bus width
StallBus, 6, stall vector width; Stop=1, NoStop=0

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
stall  in  6  pipeline stall vector; stall[2]=EX, stall[3]=MEM
id_to_ex_bus  in  145  {pc[144:113], op[112:108], src_a[107:76], src_b[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], store_data[31:0]}
ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
data_sram_en  out  1  SRAM access enable
data_sram_wen  out  4  byte write enables
data_sram_addr  out  32  = ex_result
data_sram_wdata  out  32  = store_data
ex_wreg / ex_waddr / ex_wdata  out  1/5/32  forwarding to ID: rf_we, rf_waddr, ex_result
ex_is_load  out  1  data_ram_en & sel_rf_res; used for load-use hazard
stallreq_for_ex  out  1  EX requests a stall (divider busy)

Behaviour:
- Input register id_to_ex_bus_r:
  - rst: cleared to 0 asynchronously.
  - stall[2]=Stop and stall[3]=NoStop: loads 0 (bubble).
  - stall[2]=NoStop: loads id_to_ex_bus.
  - Otherwise: holds.
- All outputs are combinational from id_to_ex_bus_r, HI, LO and the divider state. After reset every output is 0.
- "Retire" means stall[2]=NoStop at a rising edge: the current EX instruction leaves. HI/LO are written only on retire.
- Ops on a=src_a, b=src_b:
  - 0 ADD a+b, mod 2^32, no overflow trap.
  - 1 SUB a-b.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT signed, 7 SLTU unsigned; result 0/1.
  - 8 SLL b<<a[4:0]; 9 SRL b>>a[4:0]; 10 SRA b>>>a[4:0].
  - 11 LUI {b[15:0],16'h0}.
  - 12 MFHI, result=HI; 13 MFLO, result=LO.
  - 14 MTHI, HI<=a on retire; 15 MTLO, LO<=a on retire.
  - 16 DIV, 17 DIVU.
  - 18 MULT, 19 MULTU: {HI,LO}<=a*b, 64-bit signed/unsigned, on retire.
  - 20-31: result 0, no side effects.
  - Ops 14-19 give ex_result=0.
- Loads and stores use ADD for the address; data_sram_en/wen pass through from the bus.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY: when op is DIV/DIVU and b!=0. Latch |a|, |b| (signed) or a, b (unsigned) and the sign flags; cnt<=0. stallreq=1 in this cycle.
  - BUSY: one restoring step per cycle; cnt++; stallreq=1. After step 32 (cnt=31) -> DONE.
  - DONE: stallreq=0. On retire: LO<=quotient, HI<=remainder, then -> IDLE. If not retiring, hold DONE.
  - Signed results: quotient negated if the signs of a and b differ; remainder takes the sign of a. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Latency: a DIV with b!=0 occupies EX for 34 cycles when there is no external stall.
  - b==0: no stall, HI/LO unchanged, instruction retires normally.
- A bubble (op=0, rf_we=0, data_ram_en=0) never changes HI/LO or the FSM.
- rst during BUSY/DONE: FSM returns to IDLE, HI=LO=0, stallreq=0, and the divide is abandoned.
- Simultaneous events: a MULT/MTHI retiring while the FSM is IDLE cannot overlap a divide, because the FSM only leaves IDLE for a DIV in EX.

Test Plan:
1. Reset mid-stream: assert rst asynchronously between edges -> all outputs 0 immediately; stallreq=0; a later MFHI returns 0.
2. ADD a=0x7FFFFFFF, b=1, rf_we=1, waddr=5 -> ex_result=0x80000000, ex_wreg=1, ex_waddr=5; SLT a=-1, b=1 -> 1; SLTU same operands -> 0.
3. Store: data_ram_en=1, wen=4'b0011, a=0x1000, b=4, store_data=0xDEAD -> data_sram_addr=0x1004, wdata=0xDEAD, ex_is_load=0. Same operands with sel_rf_res=1, wen=0 -> ex_is_load=1.
4. DIV a=-7, b=2, stall generated from stallreq -> stallreq high exactly 33 cycles; then MFLO=0xFFFFFFFD (-3) and MFHI=0xFFFFFFFF (-1). DIVU 7/0 -> no stall, HI/LO unchanged.
5. MULTU a=0xFFFFFFFF, b=2 -> HI=1, LO=0xFFFFFFFE. MULT with same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
6. Stall[2]=Stop, stall[3]=NoStop with a new bus pending -> next cycle ex_to_mem_bus=0. Stall[2]=Stop, stall[3]=Stop -> bus held. An external stall in DONE delays the HI/LO write until retire.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS execute stage - ALU, data SRAM request, HI/LO, 32-step divider
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int ID_TO_EX_WD  = 145,
    parameter int EX_TO_MEM_WD = 76,
    parameter int STALL_BUS    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_wreg,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex
);

    localparam logic       c_stop    = 1'b1;
    localparam logic       c_nostop  = 1'b0;
    localparam logic [4:0] c_op_add  = 5'd0,  c_op_sub  = 5'd1,  c_op_and   = 5'd2;
    localparam logic [4:0] c_op_or   = 5'd3,  c_op_xor  = 5'd4,  c_op_nor   = 5'd5;
    localparam logic [4:0] c_op_slt  = 5'd6,  c_op_sltu = 5'd7,  c_op_sll   = 5'd8;
    localparam logic [4:0] c_op_srl  = 5'd9,  c_op_sra  = 5'd10, c_op_lui   = 5'd11;
    localparam logic [4:0] c_op_mfhi = 5'd12, c_op_mflo = 5'd13, c_op_mthi  = 5'd14;
    localparam logic [4:0] c_op_mtlo = 5'd15, c_op_div  = 5'd16, c_op_divu  = 5'd17;
    localparam logic [4:0] c_op_mult = 5'd18, c_op_multu = 5'd19;
    localparam logic [1:0] c_st_idle = 2'd0,  c_st_busy = 2'd1,  c_st_done  = 2'd2;

    logic [ID_TO_EX_WD-1:0] r_bus;
    logic [31:0] r_hi, r_lo;
    logic [1:0]  r_state, w_next_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem, r_quo, r_dvs;
    logic        r_neg_q, r_neg_r;
    logic        w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus <= '0;
        end else if (stall[2] == c_stop && stall[3] == c_nostop) begin
            r_bus <= '0;
        end else if (stall[2] == c_nostop) begin
            r_bus <= id_to_ex_bus;
        end
    end

    logic [31:0] w_pc, w_a, w_b, w_store_data;
    logic [4:0]  w_op, w_rf_waddr;
    logic [3:0]  w_ram_wen;
    logic        w_ram_en, w_sel_rf_res, w_rf_we, w_retire;

    assign {w_pc, w_op, w_a, w_b, w_ram_en, w_ram_wen, w_sel_rf_res,
            w_rf_we, w_rf_waddr, w_store_data} = r_bus;
    assign w_retire = (stall[2] == c_nostop);
    assign w_unused = ^{stall[STALL_BUS-1:4], stall[1:0]};

    logic [31:0] w_result;
    always_comb begin
        w_result = 32'h0;
        case (w_op)
            c_op_add:  w_result = w_a + w_b;
            c_op_sub:  w_result = w_a - w_b;
            c_op_and:  w_result = w_a & w_b;
            c_op_or:   w_result = w_a | w_b;
            c_op_xor:  w_result = w_a ^ w_b;
            c_op_nor:  w_result = ~(w_a | w_b);
            c_op_slt:  w_result = {31'h0, $signed(w_a) < $signed(w_b)};
            c_op_sltu: w_result = {31'h0, w_a < w_b};
            c_op_sll:  w_result = w_b << w_a[4:0];
            c_op_srl:  w_result = w_b >> w_a[4:0];
            c_op_sra:  w_result = $signed(w_b) >>> w_a[4:0];
            c_op_lui:  w_result = {w_b[15:0], 16'h0};
            c_op_mfhi: w_result = r_hi;
            c_op_mflo: w_result = r_lo;
            default:   w_result = 32'h0;
        endcase
    end

    // Sign- or zero-extend to 64 bits so one unsigned multiply covers both MULT forms.
    logic        w_mul_signed;
    logic [63:0] w_mul_a, w_mul_b, w_prod;
    assign w_mul_signed = (w_op == c_op_mult);
    assign w_mul_a = {{32{w_mul_signed & w_a[31]}}, w_a};
    assign w_mul_b = {{32{w_mul_signed & w_b[31]}}, w_b};
    assign w_prod  = w_mul_a * w_mul_b;

    logic        w_is_div, w_div_signed, w_div_start;
    logic [31:0] w_abs_a, w_abs_b, w_quo_final, w_rem_final;
    logic [32:0] w_shift, w_diff;
    assign w_is_div     = (w_op == c_op_div) || (w_op == c_op_divu);
    assign w_div_signed = (w_op == c_op_div);
    assign w_div_start  = (r_state == c_st_idle) && w_is_div && (w_b != 32'h0);
    assign w_abs_a      = (w_div_signed && w_a[31]) ? -w_a : w_a;
    assign w_abs_b      = (w_div_signed && w_b[31]) ? -w_b : w_b;
    assign w_shift      = {r_rem, r_quo[31]};
    assign w_diff       = w_shift - {1'b0, r_dvs};
    assign w_quo_final  = r_neg_q ? -r_quo : r_quo;
    assign w_rem_final  = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_div_start) w_next_state = c_st_busy;
            c_st_busy: if (r_cnt == 5'd31) w_next_state = c_st_done;
            c_st_done: if (w_retire) w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        stallreq_for_ex = w_div_start || (r_state == c_st_busy);
    end

    // Restoring step: the dividend shifts out of r_quo while quotient bits shift in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 5'd0;
            r_rem   <= 32'h0;
            r_quo   <= 32'h0;
            r_dvs   <= 32'h0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_div_start) begin
            r_cnt   <= 5'd0;
            r_rem   <= 32'h0;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= w_div_signed & (w_a[31] ^ w_b[31]);
            r_neg_r <= w_div_signed & w_a[31];
        end else if (r_state == c_st_busy) begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else if (w_retire) begin
            if (r_state == c_st_done) begin
                r_lo <= w_quo_final;
                r_hi <= w_rem_final;
            end else begin
                case (w_op)
                    c_op_mthi:             r_hi <= w_a;
                    c_op_mtlo:             r_lo <= w_a;
                    c_op_mult, c_op_multu: {r_hi, r_lo} <= w_prod;
                    default: ;
                endcase
            end
        end
    end

    assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we,
                              w_rf_waddr, w_result};
    assign data_sram_en    = w_ram_en;
    assign data_sram_wen   = w_ram_wen;
    assign data_sram_addr  = w_result;
    assign data_sram_wdata = w_store_data;
    assign ex_wreg         = w_rf_we;
    assign ex_waddr        = w_rf_waddr;
    assign ex_wdata        = w_result;
    assign ex_is_load      = w_ram_en & w_sel_rf_res;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Scoreboard bench for ex_stage with a reference HI/LO/ALU model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    localparam logic [5:0] c_stall_none   = 6'b000000;
    localparam logic [5:0] c_stall_hold   = 6'b001111;
    localparam logic [5:0] c_stall_bubble = 6'b000111;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall, r_ext_stall;
    logic [144:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic         data_sram_en, ex_wreg, ex_is_load, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata, ex_wdata;
    logic [4:0]   ex_waddr;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
        .ex_wdata(ex_wdata), .ex_is_load(ex_is_load), .stallreq_for_ex(stallreq_for_ex)
    );

    always #5 clk = ~clk;
    assign stall = stallreq_for_ex ? c_stall_hold : r_ext_stall;

    typedef struct packed {
        logic [75:0] bus;
        logic [31:0] sd;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         r_mon;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0, pc_ctr = 32'h0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: computes the result and applies HI/LO effects in program order.
    task automatic prep(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic [3:0] wen, input logic sel,
                        input logic we, input logic [4:0] wa, input logic [31:0] sd);
        logic [31:0] res;
        logic [63:0] p;
        longint      q, r;
        res = 32'h0;
        case (op)
            5'd0:  res = a + b;
            5'd1:  res = a - b;
            5'd2:  res = a & b;
            5'd3:  res = a | b;
            5'd4:  res = a ^ b;
            5'd5:  res = ~(a | b);
            5'd6:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  res = (a < b) ? 32'd1 : 32'd0;
            5'd8:  res = b << a[4:0];
            5'd9:  res = b >> a[4:0];
            5'd10: res = $signed(b) >>> a[4:0];
            5'd11: res = {b[15:0], 16'h0};
            5'd12: res = m_hi;
            5'd13: res = m_lo;
            5'd14: m_hi = a;
            5'd15: m_lo = a;
            5'd16: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            5'd17: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            5'd18: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = p;
            end
            5'd19: begin
                p = {32'h0, a} * {32'h0, b};
                {m_hi, m_lo} = p;
            end
            default: res = 32'h0;
        endcase
        pc_ctr += 32'd4;
        id_to_ex_bus = {pc_ctr, op, a, b, en, wen, sel, we, wa, sd};
        sb_q.push_back({pc_ctr, en, wen, sel, we, wa, res, sd});
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic en, input logic [3:0] wen, input logic sel,
                         input logic we, input logic [4:0] wa, input logic [31:0] sd);
        int n;
        n = 0;
        @(negedge clk);
        while (stall[2] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("issue_timeout", n, 0);
        prep(op, a, b, en, wen, sel, we, wa, sd);
        @(posedge clk);
        #1 id_to_ex_bus = '0;
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0);
    endtask

    // Every retiring non-bubble instruction is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ex_to_mem_bus[75:44] != 32'h0 && !stall[2]) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", ex_to_mem_bus[75:44], 0);
            end else begin
                r_mon = sb_q.pop_front();
                check("bus", ex_to_mem_bus, r_mon.bus);
                check("sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                      {r_mon.bus[43], r_mon.bus[42:39], r_mon.bus[31:0], r_mon.sd});
                check("fwd", {ex_wreg, ex_waddr, ex_wdata, ex_is_load},
                      {r_mon.bus[37], r_mon.bus[36:32], r_mon.bus[31:0],
                       r_mon.bus[43] & r_mon.bus[38]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [75:0] exp_a;
        int n;
        rst = 1'b1;
        id_to_ex_bus = '0;
        r_ext_stall = c_stall_none;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus", ex_to_mem_bus, 0);
        check("rst_stallreq", stallreq_for_ex, 0);
        check("rst_ports", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                            ex_wreg, ex_waddr, ex_wdata, ex_is_load}, 0);
        rst = 1'b0;

        issue(5'd0, 32'h7FFFFFFF, 32'h1, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h0);
        alu(5'd6, 32'hFFFFFFFF, 32'h1);
        alu(5'd7, 32'hFFFFFFFF, 32'h1);
        for (int i = 0; i < 12; i++) alu(5'(i), $urandom, $urandom);
        for (int i = 0; i < 3; i++) alu(5'(20 + $urandom_range(0, 11)), $urandom, $urandom);

        issue(5'd0, 32'h1000, 32'h4, 1'b1, 4'b0011, 1'b0, 1'b0, 5'd0, 32'hDEAD);
        issue(5'd0, 32'h1000, 32'h4, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd8, 32'hDEAD);

        alu(5'd19, 32'hFFFFFFFF, 32'h2);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd18, 32'hFFFFFFFF, 32'h2);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd14, 32'h1234, 32'h0);
        alu(5'd15, 32'h5678, 32'h0);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);

        alu(5'd16, 32'hFFFFFFF9, 32'h2);
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("div_stall_cycles", n, 33);
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd17, 32'h7, 32'h0);
        check("div0_nostall", stallreq_for_ex, 0);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd16, 32'h80000000, 32'hFFFFFFFF);
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd17, $urandom, 32'($urandom_range(1, 1000)));
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd16, 32'd12345, 32'hFFFFFFF9);
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);

        // Hold then bubble with a new instruction pending on the input bus.
        alu(5'd0, 32'h11, 32'h22);
        r_ext_stall = c_stall_hold;
        exp_a = sb_q[$].bus;
        prep(5'd1, 32'h50, 32'h8, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("hold_bus", ex_to_mem_bus, exp_a);
        r_ext_stall = c_stall_bubble;
        @(posedge clk);
        #1;
        check("bubble_bus", ex_to_mem_bus, 0);
        sb_q.delete(0);
        r_ext_stall = c_stall_none;
        @(posedge clk);
        #1 id_to_ex_bus = '0;

        // External stall while the divider sits in DONE.
        alu(5'd17, 32'd100, 32'd7);
        r_ext_stall = c_stall_hold;
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("done_hold_stallreq", stallreq_for_ex, 0);
        check("done_hold_pc", ex_to_mem_bus[75:44], sb_q[$].bus[75:44]);
        r_ext_stall = c_stall_none;
        alu(5'd13, 32'h0, 32'h0);
        alu(5'd12, 32'h0, 32'h0);

        // Asynchronous reset in the middle of a divide.
        alu(5'd16, 32'd1000, 32'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("busy_stallreq", stallreq_for_ex, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_stallreq", stallreq_for_ex, 0);
        check("midrst_bus", ex_to_mem_bus, 0);
        sb_q.delete();
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        alu(5'd12, 32'h0, 32'h0);
        alu(5'd13, 32'h0, 32'h0);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
